// File: rtl/div_share_sched_if.sv
// Request/response/divider bundle between NREQ requesters, the shared-divider scheduler and its consumer.
// The scheduler takes the slave side; requesters, the divider and the consumer take the master side.
interface div_share_sched_if #(
    parameter int NUMER_W = 8,
    parameter int DENOM_W = 4,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*NUMER_W-1:0] req_numer;
    logic [NREQ*DENOM_W-1:0] req_denom;
    logic [NREQ-1:0]         req_ready;
    logic [NUMER_W-1:0]      div_numer;
    logic [DENOM_W-1:0]      div_denom;
    logic [NUMER_W-1:0]      div_quot;
    logic [DENOM_W-1:0]      div_rem;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [NUMER_W-1:0]      rsp_quot;
    logic [DENOM_W-1:0]      rsp_rem;
    logic                    rsp_dbz;

    modport master (
        output req_valid, req_numer, req_denom, div_quot, div_rem, rsp_ready,
        input  req_ready, div_numer, div_denom, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );

    modport slave (
        input  req_valid, req_numer, req_denom, div_quot, div_rem, rsp_ready,
        output req_ready, div_numer, div_denom, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dbz
    );
endinterface

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one combinational divider among NREQ requesters.
// One job in flight: capture operands, hold them DIV_LAT cycles, register the result, return it tagged.
module div_share_sched #(
    parameter int NUMER_W = 8,
    parameter int DENOM_W = 4,
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int DIV_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    div_share_sched_if.slave bus,
    output logic             busy
);
    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_next;
    logic [NUMER_W-1:0] grant_numer;
    logic [DENOM_W-1:0] grant_denom;
    logic               grant_dbz;

    // Circular search starting at the round-robin pointer; first valid wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        grant_numer = bus.req_numer[int'(grant_idx)*NUMER_W +: NUMER_W];
        grant_denom = bus.req_denom[int'(grant_idx)*DENOM_W +: DENOM_W];
        grant_dbz   = (grant_denom == '0);
        rr_next     = ID_W'((int'(grant_idx) + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_found) state_d = grant_dbz ? RESP : WAIT;
            WAIT: if (cnt_q == '0) state_d = RESP;
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: if (grant_found) bus.req_ready[grant_idx] = 1'b1;
            WAIT: busy = 1'b1;
            RESP: begin
                busy          = 1'b1;
                bus.rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Divide-by-zero jobs skip the divider entirely and answer with a zero result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q          <= '0;
            cnt_q         <= '0;
            bus.div_numer <= '0;
            bus.div_denom <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_quot  <= '0;
            bus.rsp_rem   <= '0;
            bus.rsp_dbz   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (grant_found) begin
                    bus.div_numer <= grant_numer;
                    bus.div_denom <= grant_denom;
                    bus.rsp_id    <= grant_idx;
                    rr_q          <= rr_next;
                    if (grant_dbz) begin
                        bus.rsp_quot <= '0;
                        bus.rsp_rem  <= '0;
                        bus.rsp_dbz  <= 1'b1;
                    end else begin
                        cnt_q <= CNT_W'(DIV_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        bus.rsp_quot <= bus.div_quot;
                        bus.rsp_rem  <= bus.div_rem;
                        bus.rsp_dbz  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
